pool2d_engine: RTL and testbench
================================

Name: pool2d_engine

Overview:
- Parametrised 2-D pooling engine; next generation of the fixed 28x28, 2x2 average-pooling stage in the digit-recognition network.
- Reads a signed image from a synchronous pixel memory, computes KxK average or max pooling per window, and writes results to a pooled-feature buffer that the hidden dense layer consumes.
- Adds start/busy/done handshake, run-time mode select and configurable geometry.

Parameters:
- DATA_W, 8, signed pixel width
- IMG_W, 28, image width in pixels (multiple of K)
- IMG_H, 28, image height in pixels (multiple of K)
- K, 2, window size and stride; power of two, 2 or 4
- OUT_W, 16, signed output word width (>= DATA_W)
- ADDR_W, 10, pixel address width (2^ADDR_W >= IMG_W*IMG_H)
- OADDR_W, 8, output address width (2^OADDR_W >= (IMG_W/K)*(IMG_H/K))

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a pass; sampled only in IDLE
- mode  in  1  0 = average, 1 = max; latched with start
- busy  out  1  high from the cycle after accepted start through the done cycle
- done  out  1  one-cycle pulse after the final write
- rd_en  out  1  pixel read strobe
- rd_addr  out  ADDR_W  pixel address
- rd_data  in  DATA_W  signed pixel; valid exactly one cycle after rd_en
- wr_en  out  1  pooled-result write strobe
- wr_addr  out  OADDR_W  pooled index, row-major
- wr_data  out  OUT_W  signed pooled result

Behaviour:
- Reset: state IDLE; busy, done, rd_en, wr_en = 0; rd_addr, wr_addr, wr_data = 0; window counters and accumulator cleared.
- Reset mid-pass: abort immediately. No further rd_en or wr_en. done is not pulsed.
- FSM states: IDLE, READ, DRAIN, WRITE, DONE.
- IDLE, start=1: latch mode; window row/col = 0; go to READ.
- READ: asserts rd_en for K*K consecutive cycles, tap t = 0..K*K-1 in row-major order.
  - rd_addr = (wrow*K + t/K)*IMG_W + wcol*K + t%K.
  - After the last tap, go to DRAIN.
- Accumulation: each rd_data is folded in during the cycle after its rd_en.
  - Average: signed sum, width DATA_W + 2*log2(K).
  - Max: signed compare; the first tap initialises the running value.
- DRAIN: one cycle to fold the last tap; go to WRITE.
- WRITE: wr_en = 1 for one cycle.
  - wr_addr = wrow*(IMG_W/K) + wcol.
  - wr_data = (sum >>> 2*log2(K)), an arithmetic shift (floor toward -inf), or the max value; sign-extended to OUT_W.
  - Then clear the accumulator and advance wcol; on wcol wrap, advance wrow.
  - Not last window: go to READ. Last window: go to DONE.
- Window cadence: K*K+2 cycles; the next window's first rd_en is in the cycle after wr_en.
- DONE: done = 1 and busy = 1 for one cycle; then IDLE.
- start while busy (READ/DRAIN/WRITE/DONE): ignored; mode is not re-latched.
- start in the cycle after done (IDLE): accepted normally; back-to-back passes allowed.
- wr_data, wr_addr and rd_addr hold their last value when the corresponding strobe is low.
- Timing (start sampled in cycle 0):
  - First rd_en is in cycle 1.
  - Window w writes in cycle (w+1)*(K*K+2).
  - done is in cycle N*(K*K+2)+1, where N = (IMG_W/K)*(IMG_H/K).

Test Plan:
- Avg, 4x4 image, K=2, pixels = index 0..15, start pulse -> four writes at cycles 6, 12, 18, 24 with addr 0..3, data 2, 4, 10, 12 (floor of 2.5, 4.5, 10.5, 12.5); done in cycle 25; busy low in cycle 26.
- Avg, signed floor, window {-1,-2,-3,-4}, OUT_W=16 -> wr_data = 16'hFFFD (-3). Window {-128 x4} -> 16'hFF80, no overflow.
- Max, window {-5,-7,-2,-9} -> wr_data = 16'hFFFE (-2). Window {127,-128,0,1} -> 16'h007F.
- Default 28x28 K=2 avg, random image -> 196 writes, addresses 0..195 in order; values match a software model; done in cycle 1177.
- start and mode=1 re-asserted during a running avg pass -> ignored; all results remain averages; exactly one done.
- reset asserted at cycle 40 of a pass -> from the next cycle rd_en = wr_en = busy = done = 0; a fresh start then reproduces window 0 at cycle 6 after it.

Source files
------------

// File: rtl/pool2d_engine.sv
// KxK average/max pooling over a signed image held in a synchronous pixel memory.
// Each window takes K*K+2 cycles: K*K reads, one drain cycle to fold the last tap, one write.
module pool2d_engine #(
  parameter int DATA_W  = 8,
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int K       = 2,
  parameter int OUT_W   = 16,
  parameter int ADDR_W  = 10,
  parameter int OADDR_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  output logic               busy,
  output logic               done,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [DATA_W-1:0]  rd_data,
  output logic               wr_en,
  output logic [OADDR_W-1:0] wr_addr,
  output logic [OUT_W-1:0]   wr_data
);

  localparam int LOG2K = $clog2(K);
  localparam int SUM_W = DATA_W + 2*LOG2K;
  localparam int WX    = IMG_W / K;
  localparam int WY    = IMG_H / K;
  localparam int TAPS  = K * K;
  localparam int TW    = $clog2(TAPS);
  localparam int CW    = $clog2(WX + 1);
  localparam int RW    = $clog2(WY + 1);

  typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;

  state_t                   state_q;
  logic                     mode_q;
  logic [TW-1:0]            tap_q;
  logic [CW-1:0]            wcol_q;
  logic [RW-1:0]            wrow_q;
  logic signed [SUM_W-1:0]  acc_q, acc_d;
  logic                     fold_vld_q, fold_first_q;
  logic                     busy_q, done_q, rd_en_q, wr_en_q;
  logic [ADDR_W-1:0]        rd_addr_q;
  logic [OADDR_W-1:0]       wr_addr_q;
  logic [OUT_W-1:0]         wr_data_q, wr_data_d;
  logic signed [SUM_W-1:0]  pix, shifted, res_sel;
  logic signed [DATA_W-1:0] res_narrow;
  logic                     last_col, last_row;

  function automatic logic [ADDR_W-1:0] addr_of(input int r, input int c, input int t);
    return ADDR_W'((r*K + t/K)*IMG_W + c*K + t%K);
  endfunction

  // Pixel arriving this cycle belongs to the tap read one cycle earlier.
  always_comb begin
    pix   = SUM_W'($signed(rd_data));
    acc_d = acc_q;
    if (fold_vld_q) begin
      if (fold_first_q)  acc_d = pix;
      else if (mode_q)   acc_d = (pix > acc_q) ? pix : acc_q;
      else               acc_d = acc_q + pix;
    end
    shifted    = acc_d >>> (2*LOG2K);
    res_sel    = mode_q ? acc_d : shifted;
    res_narrow = res_sel[DATA_W-1:0];
    wr_data_d  = OUT_W'(res_narrow);
  end

  assign last_col = (wcol_q == CW'(WX-1));
  assign last_row = (wrow_q == RW'(WY-1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      mode_q       <= 1'b0;
      tap_q        <= '0;
      wcol_q       <= '0;
      wrow_q       <= '0;
      acc_q        <= '0;
      fold_vld_q   <= 1'b0;
      fold_first_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      fold_vld_q   <= rd_en_q;
      fold_first_q <= rd_en_q && (tap_q == '0);
      acc_q        <= acc_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            mode_q    <= mode;
            wcol_q    <= '0;
            wrow_q    <= '0;
            tap_q     <= '0;
            rd_en_q   <= 1'b1;
            rd_addr_q <= addr_of(0, 0, 0);
            busy_q    <= 1'b1;
            state_q   <= READ;
          end
        end
        READ: begin
          if (tap_q == TW'(TAPS-1)) begin
            rd_en_q <= 1'b0;
            tap_q   <= '0;
            state_q <= DRAIN;
          end else begin
            tap_q     <= tap_q + 1'b1;
            rd_addr_q <= addr_of(int'(wrow_q), int'(wcol_q), int'(tap_q) + 1);
          end
        end
        DRAIN: begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= OADDR_W'(int'(wrow_q)*WX + int'(wcol_q));
          wr_data_q <= wr_data_d;
          state_q   <= WRITE;
        end
        WRITE: begin
          wr_en_q <= 1'b0;
          acc_q   <= '0;
          if (last_col) begin
            wcol_q <= '0;
            if (last_row) begin
              wrow_q  <= '0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              wrow_q    <= wrow_q + 1'b1;
              rd_en_q   <= 1'b1;
              rd_addr_q <= addr_of(int'(wrow_q) + 1, 0, 0);
              state_q   <= READ;
            end
          end else begin
            wcol_q    <= wcol_q + 1'b1;
            rd_en_q   <= 1'b1;
            rd_addr_q <= addr_of(int'(wrow_q), int'(wcol_q) + 1, 0);
            state_q   <= READ;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_pool2d_engine.sv
// Random-image bench for pool2d_engine (28x28, K=2) against an arithmetic pooling model.
module tb_pool2d_engine;

  localparam int NPIX = 784;
  localparam int NWIN = 196;
  localparam int CAD  = 6;

  logic        clk = 1'b0;
  logic        reset, start, mode;
  logic        busy, done, rd_en, wr_en;
  logic [9:0]  rd_addr;
  logic [7:0]  rd_data;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;

  logic [7:0]  mem [NPIX];
  logic [15:0] exp_dat [NWIN];
  logic [15:0] got_dat [256];
  int          got_addr [256];
  int          got_cyc [256];
  int          nwr, ndone, done_cyc;
  int          n_chk = 0, n_err = 0;

  pool2d_engine dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
  endtask

  // Window (r,c) taps in row-major order.
  task automatic set_win(input int r, input int c, input int a, input int b, input int d, input int e);
    mem[(2*r)*28 + 2*c]       = 8'(a);
    mem[(2*r)*28 + 2*c + 1]   = 8'(b);
    mem[(2*r+1)*28 + 2*c]     = 8'(d);
    mem[(2*r+1)*28 + 2*c + 1] = 8'(e);
  endtask

  task automatic build_model(input bit m);
    for (int r = 0; r < 14; r++)
      for (int c = 0; c < 14; c++) begin
        int sum, mx, v, res;
        sum = 0;
        mx  = -1000;
        for (int dy = 0; dy < 2; dy++)
          for (int dx = 0; dx < 2; dx++) begin
            v = $signed(mem[(2*r+dy)*28 + 2*c + dx]);
            sum += v;
            if (v > mx) mx = v;
          end
        if (m) res = mx;
        else   res = (sum >= 0) ? sum / 4 : -((-sum + 3) / 4);
        exp_dat[r*14 + c] = 16'(res);
      end
  endtask

  // Start sampled in cycle 0; the loop index c is the cycle number being observed.
  task automatic run_pass(input bit m, input bit poke);
    nwr = 0; ndone = 0; done_cyc = -1;
    @(negedge clk); start = 1'b1; mode = m;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= 2000 && ndone == 0; c++) begin
      if (poke && ((c >= 10 && c <= 12) || c == 1177)) begin
        start = 1'b1; mode = 1'b1;
      end else start = 1'b0;
      if (wr_en && nwr < 256) begin
        got_addr[nwr] = int'(wr_addr);
        got_dat[nwr]  = wr_data;
        got_cyc[nwr]  = c;
        nwr++;
      end
      if (done) begin ndone++; done_cyc = c; end
      @(negedge clk);
    end
    start = 1'b0;
    expect_eq("busy_after_done", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    expect_eq("done_count", 32'(ndone), 32'd1);
    expect_eq("done_cycle", 32'(done_cyc), 32'(NWIN*CAD + 1));
    expect_eq("write_count", 32'(nwr), 32'(NWIN));
    for (int w = 0; w < nwr && w < NWIN; w++) begin
      expect_eq("wr_addr", 32'(got_addr[w]), 32'(w));
      expect_eq("wr_data", 32'(got_dat[w]), 32'(exp_dat[w]));
      expect_eq("wr_cycle", 32'(got_cyc[w]), 32'((w + 1) * CAD));
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0;
    for (int i = 0; i < NPIX; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    expect_eq("rst_busy", 32'(busy), 32'd0);
    expect_eq("rst_done", 32'(done), 32'd0);
    expect_eq("rst_rd_en", 32'(rd_en), 32'd0);
    expect_eq("rst_wr_en", 32'(wr_en), 32'd0);
    expect_eq("rst_rd_addr", 32'(rd_addr), 32'd0);
    expect_eq("rst_wr_addr", 32'(wr_addr), 32'd0);
    expect_eq("rst_wr_data", 32'(wr_data), 32'd0);

    // Average with signed-floor and full-negative windows.
    fill_random();
    set_win(0, 0, -1, -2, -3, -4);
    set_win(0, 1, -128, -128, -128, -128);
    build_model(1'b0);
    run_pass(1'b0, 1'b0);
    expect_eq("avg_floor_neg", 32'(got_dat[0]), 32'h0000FFFD);
    expect_eq("avg_min_no_ovf", 32'(got_dat[1]), 32'h0000FF80);

    // Max with all-negative and extreme-value windows.
    fill_random();
    set_win(0, 0, -5, -7, -2, -9);
    set_win(0, 1, 127, -128, 0, 1);
    build_model(1'b1);
    run_pass(1'b1, 1'b0);
    expect_eq("max_neg", 32'(got_dat[0]), 32'h0000FFFE);
    expect_eq("max_extreme", 32'(got_dat[1]), 32'h0000007F);

    // Index ramp in the top-left 4x4; start/mode=1 poked mid-pass and in the done cycle.
    fill_random();
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) mem[y*28 + x] = 8'(y*4 + x);
    build_model(1'b0);
    run_pass(1'b0, 1'b1);
    expect_eq("ramp_w0", 32'(got_dat[0]), 32'd2);
    expect_eq("ramp_w1", 32'(got_dat[1]), 32'd4);
    expect_eq("ramp_w14", 32'(got_dat[14]), 32'd10);
    expect_eq("ramp_w15", 32'(got_dat[15]), 32'd12);

    // Reset at cycle 40 of a pass, then a fresh pass.
    @(negedge clk); start = 1'b1; mode = 1'b0;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c < 40; c++) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      expect_eq("abort_rd_en", 32'(rd_en), 32'd0);
      expect_eq("abort_wr_en", 32'(wr_en), 32'd0);
      expect_eq("abort_busy", 32'(busy), 32'd0);
      expect_eq("abort_done", 32'(done), 32'd0);
    end
    reset = 1'b0;
    fill_random();
    build_model(1'b0);
    run_pass(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
